// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the 4-way round-robin bus arbiter.
package bus_arb_pkg;

    localparam int NREQ  = 4;  // number of requesters
    localparam int IDX_W = 2;  // width of a requester index
    localparam int TA_W  = 3;  // turnaround counter width (TA_CYCLES up to 7)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

endpackage

// File: rtl/bus_arb_rr4_rr_pick.sv
// Rotating priority encoder: returns the first requester at or after ptr_i
// (wrapping modulo NREQ) whose request bit is set.
module rr_pick
    import bus_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit to ptr_i wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arb_rr4.sv
// Round-robin arbiter for a shared 4:1 mux / tristate bus.
// One owner at a time, no preemption, and a TA_CYCLES turnaround gap with all
// output enables low between owners. All outputs are registered; oe equals gnt.
// Optional feature: define TIMEOUT_EN to force release of an owner that has
// held the bus for MAX_HOLD consecutive cycles (one-cycle timeout pulse).
// Handshake: req_i is a level; a requester keeps it high for as long as it
// wants the bus and sees ownership through gnt_o/oe_o. Dropping req_i while
// owning releases the bus; the grant drops on the following cycle.
module bus_arb_rr4
    import bus_arb_pkg::*;
#(
    parameter int TA_CYCLES = 1,
    parameter int MAX_HOLD  = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic [1:0] sel_o,
    output logic [3:0] oe_o,
    output logic       busy_o,
    output logic       timeout_o,
    output logic [1:0] state_o
);

    if (TA_CYCLES < 1 || TA_CYCLES > 7 || MAX_HOLD < 2) begin : g_bad_param
        $error("bus_arb_rr4: TA_CYCLES must be 1..7 and MAX_HOLD >= 2");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             to_q, to_d;
    logic [TA_W-1:0]  ta_q, ta_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_req;
    logic             hold_expire;

    rr_pick u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // While in GRANT, sel_q is the current owner.
    assign owner_req = req_i[sel_q];

`ifdef TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // Count GRANT cycles; the counter sits at zero outside GRANT so every new grant starts fresh.
    always_comb begin
        hold_d = '0;
        if (state_q == GRANT) begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold_expire = (hold_q == HOLD_W'(MAX_HOLD - 1));
`else
    assign hold_expire = 1'b0;
`endif

    // Next-state logic: arbitrate from IDLE or the last turnaround cycle, release on drop or expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_found) state_d = GRANT;
            end
            GRANT: begin
                if (!owner_req || hold_expire) state_d = TURN;
            end
            TURN: begin
                if (ta_q == TA_W'(TA_CYCLES - 1)) begin
                    state_d = pick_found ? GRANT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; the pointer moves only when an owner releases.
    always_comb begin
        gnt_d  = '0;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        ta_d   = '0;
        to_d   = 1'b0;
        busy_d = (state_d != IDLE);
        if (state_q == TURN) begin
            ta_d = ta_q + 1'b1;
        end
        if (state_d == GRANT) begin
            if (state_q == GRANT) begin
                gnt_d = gnt_q;
            end else begin
                gnt_d = NREQ'(1) << pick_idx;
                sel_d = pick_idx;
            end
        end
        if (state_q == GRANT && state_d == TURN) begin
            ptr_d = sel_q + IDX_W'(1);
            to_d  = owner_req & hold_expire;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            ta_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
            ta_q    <= ta_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign oe_o      = gnt_q;
    assign sel_o     = sel_q;
    assign busy_o    = busy_q;
    assign timeout_o = to_q;
    assign state_o   = state_q;

endmodule
